// File: rtl/key_input_pkg.sv
// Shared types and constants for the KEY-bank input conditioner:
// per-key state encoding, counter sizing and 50 MHz default timing.
package key_input_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        REPEATING,
        DEB_RELEASE
    } key_state_e;

    localparam int DEFAULT_NUM_KEYS        = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;     // 10 ms
    localparam int DEFAULT_HOLD_CYCLES     = 25_000_000;  // 500 ms
    localparam int DEFAULT_REPEAT_CYCLES   = 5_000_000;   // 100 ms

    // Wide enough to hold the largest of the three timing thresholds.
    function automatic int cnt_width(input int debounce, input int hold, input int rpt);
        int m;
        m = debounce;
        if (hold > m) m = hold;
        if (rpt > m)  m = rpt;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debounce / hold / auto-repeat FSM and
// registered level and pulse outputs.
module key_channel
    import key_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES);

    logic          key_meta;
    logic          key_sync;
    key_state_e    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          pressed_nxt, press_nxt, release_nxt, repeat_nxt;

    // NOTE: synchroniser flops reset to 1 (released), not 0, so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
        end
    end

    assign cnt_inc = cnt + CW'(1);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pressed_nxt = pressed;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        repeat_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!key_sync) begin
                    if (DEBOUNCE_CYCLES <= 1) begin
                        state_nxt   = HELD;
                        cnt_nxt     = '0;
                        press_nxt   = 1'b1;
                        pressed_nxt = 1'b1;
                    end else begin
                        state_nxt = DEB_PRESS;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            DEB_PRESS: begin
                if (key_sync) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_inc == DEB_LAST) begin
                    state_nxt   = HELD;
                    cnt_nxt     = '0;
                    press_nxt   = 1'b1;
                    pressed_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            HELD: begin
                if (key_sync) begin
                    state_nxt = DEB_RELEASE;
                    cnt_nxt   = '0;
                end else if (HOLD_CYCLES > 0) begin
                    if (cnt_inc == HOLD_LAST) begin
                        state_nxt  = REPEATING;
                        cnt_nxt    = '0;
                        repeat_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            REPEATING: begin
                if (key_sync) begin
                    state_nxt = DEB_RELEASE;
                    cnt_nxt   = '0;
                end else if (cnt_inc == REP_LAST) begin
                    cnt_nxt    = '0;
                    repeat_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            DEB_RELEASE: begin
                // A short return to low is a glitch: back to HELD with a fresh hold timer.
                if (!key_sync) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt_inc == DEB_LAST) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                    pressed_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            pressed       <= pressed_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            repeat_pulse  <= repeat_nxt;
        end
    end

endmodule

// File: rtl/key_input_conditioner.sv
// Conditions the active-low KEY bank into registered level, press, release
// and auto-repeat events; one independent key_channel per key.
module key_input_conditioner
    import key_input_pkg::*;
#(
    parameter int NUM_KEYS        = DEFAULT_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] PRESSED,
    output logic [NUM_KEYS-1:0] PRESS,
    output logic [NUM_KEYS-1:0] RELEASE,
    output logic [NUM_KEYS-1:0] REPEAT
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_channel (
            .clk           (CLOCK),
            .rst_n         (RESET_N),
            .key_n         (KEY[i]),
            .pressed       (PRESSED[i]),
            .press_pulse   (PRESS[i]),
            .release_pulse (RELEASE[i]),
            .repeat_pulse  (REPEAT[i])
        );
    end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with short timing
// (debounce 4, hold 20, repeat 8) and hand-derived cycle positions.
module tb_key_input_conditioner;

    localparam int NK = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key   = '1;
    logic [NK-1:0] pressed, press, release_p, repeat_p;

    int checks = 0;
    int errors = 0;

    key_input_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (8)
    ) dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .KEY     (key),
        .PRESSED (pressed),
        .PRESS   (press),
        .RELEASE (release_p),
        .REPEAT  (repeat_p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit is_repeat_hold(input int i);
        return (i == 20) || (i == 28) || (i == 36) || (i == 44) || (i == 52);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        check("reset_outputs", {pressed, press, release_p, repeat_p}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("idle_outputs", {pressed, press, release_p, repeat_p}, 32'h0);

        // 1. Clean press on key 0: the 6th edge after driving shows PRESS.
        key[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("t1_press",   press,     (i == 6) ? 4'b0001 : 4'b0000);
            check("t1_pressed", pressed,   (i == 6) ? 4'b0001 : 4'b0000);
        end
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            check("t1_press_once", press,   4'b0000);
            check("t1_level",      pressed, 4'b0001);
        end

        // 2. Clean release: debounce count starts at 0 here, so RELEASE lands on the 7th edge.
        key[0] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            check("t2_release", release_p, (i == 7) ? 4'b0001 : 4'b0000);
            check("t2_pressed", pressed,   (i < 7) ? 4'b0001 : 4'b0000);
            check("t2_quiet",   {press, repeat_p}, 8'h00);
        end
        tick(1);
        check("t2_release_once", release_p, 4'b0000);

        // 3. Bounce on key 1: low 2 / high 1, never 4 stable low samples.
        for (int i = 0; i < 10; i++) begin
            key[1] = (i % 3 == 2);
            tick(1);
            check("t3_bounce", {press[1], release_p[1], pressed[1]}, 3'b000);
        end
        key[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t3_settle", {press[1], release_p[1], pressed[1]}, 3'b000);
        end

        // Simultaneous press and release on keys 0 and 1.
        key[1:0] = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("sim_press", press, (i == 6) ? 4'b0011 : 4'b0000);
        end
        key[1:0] = 2'b11;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            check("sim_release", release_p, (i == 7) ? 4'b0011 : 4'b0000);
        end

        // 4. Hold key 2: REPEAT at +20, +28, +36, +44, +52; released after +55.
        key[2] = 1'b0;
        tick(6);
        check("t4_press", press, 4'b0100);
        for (int i = 1; i <= 62; i++) begin
            tick(1);
            check("t4_repeat",  repeat_p,  is_repeat_hold(i) ? 4'b0100 : 4'b0000);
            check("t4_release", release_p, (i == 62) ? 4'b0100 : 4'b0000);
            check("t4_pressed", pressed,   (i < 62) ? 4'b0100 : 4'b0000);
            check("t4_press",   press,     4'b0000);
            if (i == 55) key[2] = 1'b1;
        end

        // 5. Two-cycle glitch at +15: HELD re-entered at +20, so first REPEAT at +40.
        key[2] = 1'b0;
        tick(6);
        check("t5_press", press, 4'b0100);
        for (int i = 1; i <= 51; i++) begin
            tick(1);
            check("t5_repeat",  repeat_p,  (i == 40) ? 4'b0100 : 4'b0000);
            check("t5_release", release_p, (i == 51) ? 4'b0100 : 4'b0000);
            check("t5_pressed", pressed,   (i < 51) ? 4'b0100 : 4'b0000);
            if (i == 15) key[2] = 1'b1;
            if (i == 17) key[2] = 1'b0;
            if (i == 44) key[2] = 1'b1;
        end

        // 6. Reset while key 3 is held; fresh press after reset deasserts.
        key[3] = 1'b0;
        tick(6);
        check("t6_press", press, 4'b1000);
        tick(5);
        check("t6_held", pressed, 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", {pressed, press, release_p, repeat_p}, 32'h0);
        tick(1);
        check("t6_in_reset", {pressed, press, release_p, repeat_p}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("t6_repress", press,   (i == 6) ? 4'b1000 : 4'b0000);
            check("t6_level",   pressed, (i == 6) ? 4'b1000 : 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
